// File: rtl/led_sequencer.sv
// led_sequencer: drives an 8-LED bank with one of four patterns
// (BLINK, CHASE, BOUNCE, FILL). A debounced active-low push-button
// cycles the pattern. One shared tick generator paces every pattern step.
// Optional feature macro: LED_SEQUENCER_DIM_EN adds a 25% PWM dimmer
// on led_o (registered, one cycle behind the pattern register).
module led_sequencer #(
    parameter int unsigned TICK_DIV        = 32'd5000000,
    parameter int unsigned DEBOUNCE_CYCLES = 32'd250000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       button_i,
    output logic [7:0] led_o,
    output logic [1:0] mode_o
);

    typedef enum logic [1:0] {
        BLINK  = 2'd0,
        CHASE  = 2'd1,
        BOUNCE = 2'd2,
        FILL   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    logic        sync_meta;
    logic        sync_out;
    logic        stable;
    logic [23:0] db_cnt;
    logic        press;
    logic [31:0] tick_cnt;
    logic        tick;
    mode_t       mode;
    dir_t        dir;
    logic [7:0]  pat;

    // Two-flop synchronizer for the raw button level (idle high)
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
        end else begin
            sync_meta <= button_i;
            sync_out  <= sync_meta;
        end
    end

    // Debounce: accept a new level only after it persists DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stable <= 1'b1;
            db_cnt <= '0;
        end else if (sync_out == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= sync_out;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 24'd1;
        end
    end

    // A press is the accepted 1->0 transition of the debounced level
    assign press = (sync_out != stable) && (db_cnt == DB_LAST) && stable;

    // Step-tick generator; a press restarts the step period
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tick_cnt <= '0;
        end else if (press || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Mode FSM and pattern register; press takes priority over tick
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode <= BLINK;
            pat  <= '0;
            dir  <= DIR_LEFT;
        end else if (press) begin
            dir <= DIR_LEFT;
            case (mode)
                BLINK:   begin mode <= CHASE;  pat <= 8'h01; end
                CHASE:   begin mode <= BOUNCE; pat <= 8'h01; end
                BOUNCE:  begin mode <= FILL;   pat <= 8'h00; end
                default: begin mode <= BLINK;  pat <= 8'h00; end
            endcase
        end else if (tick) begin
            case (mode)
                BLINK: pat <= ~pat;
                CHASE: pat <= {pat[6:0], pat[7]};
                BOUNCE: begin
                    // Reverse at the endpoints so each end is shown for one tick only
                    if (dir == DIR_LEFT) begin
                        if (pat[7]) begin
                            pat <= {1'b0, pat[7:1]};
                            dir <= DIR_RIGHT;
                        end else begin
                            pat <= {pat[6:0], 1'b0};
                        end
                    end else begin
                        if (pat[0]) begin
                            pat <= {pat[6:0], 1'b0};
                            dir <= DIR_LEFT;
                        end else begin
                            pat <= {1'b0, pat[7:1]};
                        end
                    end
                end
                default: begin
                    if (pat == 8'hFF) begin
                        pat <= '0;
                    end else begin
                        pat <= {pat[6:0], 1'b1};
                    end
                end
            endcase
        end
    end

    assign mode_o = mode;

`ifdef LED_SEQUENCER_DIM_EN
    logic [3:0] pwm_cnt;
    logic [7:0] led_q;

    // Free-running PWM; LEDs are lit for 4 of every 16 cycles
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pwm_cnt <= '0;
            led_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            led_q   <= pat & {8{pwm_cnt < 4'd4}};
        end
    end

    assign led_o = led_q;
`else
    assign led_o = pat;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: randomized and directed checks of led_sequencer against
// a step-count reference model (TICK_DIV=4, DEBOUNCE_CYCLES=3).
module tb_led_sequencer;

    localparam int unsigned TD = 4;
    localparam int unsigned DC = 3;

    logic       clk    = 1'b0;
    logic       rstn   = 1'b0;
    logic       button = 1'b1;
    logic [7:0] led;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic       m_sync1, m_sync2, m_acc;
    int         m_run, m_cyc, m_step, m_mode, m_tot;
    logic [7:0] m_led;
    bit         m_press;

    led_sequencer #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DC)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .button_i(button),
        .led_o   (led),
        .mode_o  (mode)
    );

    always #5 clk = ~clk;

    // Pattern shown after n steps in mode m, from the pattern definitions
    function automatic logic [7:0] pat_of(input int m, input int n);
        int k;
        case (m)
            0: return (n % 2 == 1) ? 8'hFF : 8'h00;
            1: return 8'(1 << (n % 8));
            2: begin
                k = n % 14;
                if (k > 7) k = 14 - k;
                return 8'(1 << k);
            end
            default: begin
                k = n % 9;
                return 8'((1 << k) - 1);
            end
        endcase
    endfunction

    task automatic model_reset();
        m_sync1 = 1'b1; m_sync2 = 1'b1; m_acc = 1'b1;
        m_run = 0; m_cyc = 0; m_step = 0; m_mode = 0; m_tot = 0;
        m_led = 8'h00; m_press = 1'b0;
    endtask

    // One clock: drive button on the falling edge, advance the model on the rising edge
    task automatic cycle(input logic b);
        logic [7:0] prev_pat;
        int         prev_pwm;
        logic       s;
        @(negedge clk);
        button = b;
        @(posedge clk);
        prev_pat = pat_of(m_mode, m_step);
        prev_pwm = m_tot % 16;
        s = m_sync2;
        m_press = 1'b0;
        if (s != m_acc) begin
            m_run++;
            if (m_run == int'(DC)) begin
                m_press = (m_acc == 1'b1);
                m_acc = s;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (m_press) begin
            m_mode = (m_mode + 1) % 4;
            m_cyc = 0;
            m_step = 0;
        end else begin
            m_cyc++;
            if (m_cyc % int'(TD) == 0) m_step++;
        end
        m_sync2 = m_sync1;
        m_sync1 = b;
        m_tot++;
`ifdef LED_SEQUENCER_DIM_EN
        m_led = (prev_pwm < 4) ? prev_pat : 8'h00;
`else
        m_led = pat_of(m_mode, m_step);
`endif
        #1;
    endtask

    // Press until the model reports an accepted press, then release and settle
    task automatic press_once();
        int i;
        for (i = 0; i < 12 && !m_press; i++) begin
            cycle(1'b0);
            n_cmp++;
            if ({mode, led} !== {2'(m_mode), m_led}) begin
                n_bad++;
                $display("FAIL press_out t=%0t mode/led=%0d/%02h want %0d/%02h", $time, mode, led, m_mode, m_led);
            end
        end
        n_cmp++;
        if (!m_press) begin
            n_bad++;
            $display("FAIL press_timeout t=%0t no press after %0d cycles", $time, i);
        end
        for (int j = 0; j < 6; j++) begin
            cycle(1'b1);
            n_cmp++;
            if ({mode, led} !== {2'(m_mode), m_led}) begin
                n_bad++;
                $display("FAIL release_out t=%0t mode/led=%0d/%02h want %0d/%02h", $time, mode, led, m_mode, m_led);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        button = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({mode, led} !== 10'h000) begin
            n_bad++;
            $display("FAIL reset_state mode/led=%0d/%02h want 0/00", mode, led);
        end
        rstn = 1'b1;
        model_reset();
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1);
            n_cmp++;
            if ({mode, led} !== {2'(m_mode), m_led}) begin
                n_bad++;
                $display("FAIL blink_out edge %0d mode/led=%0d/%02h want %0d/%02h", i, mode, led, m_mode, m_led);
            end
`ifndef LED_SEQUENCER_DIM_EN
            if (i % 4 == 0) begin
                n_cmp++;
                if (led !== (((i / 4) % 2 == 1) ? 8'hFF : 8'h00)) begin
                    n_bad++;
                    $display("FAIL blink_step edge %0d led=%02h", i, led);
                end
            end
`endif
        end
        // Asynchronous reset between clock edges
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({mode, led} !== 10'h000) begin
            n_bad++;
            $display("FAIL async_reset mode/led=%0d/%02h want 0/00", mode, led);
        end
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_chase();
        int         first = -1;
        int         changes = 0;
        logic [1:0] pm;
        pm = mode;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0);
            n_cmp++;
            if ({mode, led} !== {2'(m_mode), m_led}) begin
                n_bad++;
                $display("FAIL chase_out edge %0d mode/led=%0d/%02h want %0d/%02h", i, mode, led, m_mode, m_led);
            end
            if (mode !== pm) begin
                changes++;
                if (first < 0) first = i;
                pm = mode;
            end
        end
        n_cmp++;
        if (first != 5) begin
            n_bad++;
            $display("FAIL press_latency edge=%0d want 5", first);
        end
        n_cmp++;
        if (changes != 1) begin
            n_bad++;
            $display("FAIL held_single_press changes=%0d want 1", changes);
        end
    endtask

    task automatic test_glitch();
        logic [1:0] m0;
        for (int i = 0; i < 6; i++) cycle(1'b1);
        m0 = mode;
        for (int i = 0; i < 10; i++) begin
            cycle((i < 2) ? 1'b0 : 1'b1);
            n_cmp++;
            if ({mode, led} !== {2'(m_mode), m_led}) begin
                n_bad++;
                $display("FAIL glitch_out t=%0t mode/led=%0d/%02h want %0d/%02h", $time, mode, led, m_mode, m_led);
            end
        end
        n_cmp++;
        if (mode !== m0) begin
            n_bad++;
            $display("FAIL glitch_ignored mode=%0d want %0d", mode, m0);
        end
        for (int k = 1; k <= 4; k++) begin
            press_once();
            n_cmp++;
            if (mode !== 2'(m0 + 2'(k))) begin
                n_bad++;
                $display("FAIL press_cycle %0d mode=%0d want %0d", k, mode, 2'(m0 + 2'(k)));
            end
        end
    endtask

    task automatic test_bounce_fill();
        logic [7:0] bt [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        logic [7:0] ft [10] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
        for (int k = 0; k < 4 && m_mode != 2; k++) press_once();
        for (int i = 0; i < 80 && m_step < 16; i++) begin
            cycle(1'b1);
            n_cmp++;
            if ({mode, led} !== {2'(m_mode), m_led}) begin
                n_bad++;
                $display("FAIL bounce_out t=%0t mode/led=%0d/%02h want %0d/%02h", $time, mode, led, m_mode, m_led);
            end
`ifndef LED_SEQUENCER_DIM_EN
            if (m_step < 16) begin
                n_cmp++;
                if (led !== bt[m_step]) begin
                    n_bad++;
                    $display("FAIL bounce_seq step %0d led=%02h want %02h", m_step, led, bt[m_step]);
                end
            end
`endif
        end
        press_once();
        for (int i = 0; i < 60 && m_step < 10; i++) begin
            cycle(1'b1);
            n_cmp++;
            if ({mode, led} !== {2'(m_mode), m_led}) begin
                n_bad++;
                $display("FAIL fill_out t=%0t mode/led=%0d/%02h want %0d/%02h", $time, mode, led, m_mode, m_led);
            end
`ifndef LED_SEQUENCER_DIM_EN
            if (m_step < 10) begin
                n_cmp++;
                if (led !== ft[m_step]) begin
                    n_bad++;
                    $display("FAIL fill_seq step %0d led=%02h want %02h", m_step, led, ft[m_step]);
                end
            end
`endif
        end
    endtask

    // Land the accepted press exactly on a cycle where a pattern step would fire
    task automatic test_press_tick_align();
        logic [7:0] init_t [4] = '{8'h00, 8'h01, 8'h01, 8'h00};
        logic [7:0] step_t [4] = '{8'hFF, 8'h02, 8'h02, 8'h01};
        int nm;
        for (int i = 0; i < 4 && (m_cyc + 5) % int'(TD) != 0; i++) cycle(1'b1);
        nm = (m_mode + 1) % 4;
        for (int i = 0; i < 5; i++) cycle(1'b0);
        n_cmp++;
        if (!m_press || mode !== 2'(nm)) begin
            n_bad++;
            $display("FAIL align_press mode=%0d want %0d", mode, nm);
        end
`ifndef LED_SEQUENCER_DIM_EN
        n_cmp++;
        if (led !== init_t[nm]) begin
            n_bad++;
            $display("FAIL align_init led=%02h want %02h", led, init_t[nm]);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1);
        n_cmp++;
        if (led !== init_t[nm]) begin
            n_bad++;
            $display("FAIL align_hold led=%02h want %02h", led, init_t[nm]);
        end
        cycle(1'b1);
        n_cmp++;
        if (led !== step_t[nm]) begin
            n_bad++;
            $display("FAIL align_step led=%02h want %02h", led, step_t[nm]);
        end
`endif
        for (int i = 0; i < 6; i++) cycle(1'b1);
    endtask

    task automatic test_random();
        int   left = 0;
        logic lvl = 1'b1;
        int   rst_at;
        rst_at = int'($urandom_range(100, 300));
        for (int i = 0; i < 400; i++) begin
            if (left == 0) begin
                lvl = 1'($urandom_range(0, 1));
                left = int'($urandom_range(1, 7));
            end
            left--;
            cycle(lvl);
            n_cmp++;
            if ({mode, led} !== {2'(m_mode), m_led}) begin
                n_bad++;
                $display("FAIL random_out t=%0t mode/led=%0d/%02h want %0d/%02h", $time, mode, led, m_mode, m_led);
            end
            if (i == rst_at) begin
                rstn = 1'b0;
                #1;
                n_cmp++;
                if ({mode, led} !== 10'h000) begin
                    n_bad++;
                    $display("FAIL random_reset mode/led=%0d/%02h want 0/00", mode, led);
                end
                rstn = 1'b1;
                model_reset();
            end
        end
    endtask

    initial begin
        test_reset();
        test_chase();
        test_glitch();
        test_bounce_fill();
        test_press_tick_align();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Board-level LED pattern controller for the 8-LED breakout demos. It owns the shared LED bank and a single step-tick generator, and sequences one of four display patterns onto the LEDs. A debounced push-button cycles through the patterns. It sits directly between the board pins (clock, button, LEDs) and replaces ad-hoc per-demo blink logic.

## Interface
- `TICK_DIV`, default 5000000: clock cycles per pattern step; legal range 2 to 2^32-1.
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive cycles a changed button level must persist before it is accepted; legal range 2 to 2^24-1.
- `clk_i` input, 1 bit: single system clock; all logic runs on its rising edge.
- `rstn_i` input, 1 bit: asynchronous, active-low reset.
- `button_i` input, 1 bit: asynchronous raw button level; low = pressed, high = released.
- `led_o` output, 8 bits: LED drive, active-high, registered.
- `mode_o` output, 2 bits: current pattern mode, registered.

## Operation
- **Synchronizer:** two flops on `button_i`, both reset to 1. The output is `s`.
- **Debounce:**
  - Keeps a `stable` level (reset 1) and a counter (reset 0).
  - Counter clears whenever `s == stable`.
  - While `s != stable`, the counter increments.
  - On a mismatch cycle with counter == DEBOUNCE_CYCLES-1: `stable <= s` and the counter clears.
  - `press` is asserted in the same cycle that `stable` transitions 1->0. Releases generate no event.
- **Tick generator:**
  - 32-bit counter, reset 0. It counts 0..TICK_DIV-1 and then wraps to 0.
  - `tick` is asserted in the cycle where counter == TICK_DIV-1.
  - The counter also clears on `press`.
- **Mode FSM:** states BLINK=0, CHASE=1, BOUNCE=2, FILL=3.
  - `press` advances the mode: 0->1->2->3->0.
  - On entering a mode, the pattern register loads that mode's initial value.
- **Patterns** (pattern register `pat`, 8 bits, plus a direction bit `dir` used by BOUNCE); each update happens on `tick`:
  - BLINK: init 00; each tick `pat <= ~pat`, giving 00, FF, 00, …
  - CHASE: init 01; rotate left: 01, 02, …, 80, 01.
  - BOUNCE: init 01 with `dir` = left.
    - Shift left up to 80, then shift right down to 01, then repeat: 01, 02, …, 80, 40, …, 01, 02.
    - The endpoints are shown for one tick only.
  - FILL: init 00; `pat <= {pat[6:0],1'b1}` until FF is reached; the next tick gives 00. This is a 9-step cycle.
- **Output:** `led_o` equals `pat` (macro absent). `mode_o` is the FSM state.
- **Simultaneous events:**
  - `press` and `tick` in the same cycle: `press` wins. Mode advances, `pat` loads the new init value and the tick counter clears; no pattern step occurs.
  - A button held low produces exactly one `press`.
  - Bounces shorter than DEBOUNCE_CYCLES are ignored.
- **Reset (any time, including mid-debounce or mid-pattern):**
  - `led_o`=00, `mode_o`=0 (BLINK), `pat`=00, `dir`=left.
  - All counters 0; synchronizer flops and `stable` = 1.

## Timing
- **Button latency:** `button_i` falls and stays low; counting the first rising edge that samples the low level as edge 1, `mode_o` and `led_o` (new init value) change on edge DEBOUNCE_CYCLES+2.
- **Pattern latency:** after reset or a mode change, the first pattern step is visible on the TICK_DIV-th rising edge. Subsequent steps follow every TICK_DIV cycles exactly.
- All outputs are flop outputs; there are no combinational paths from inputs to outputs.

## Configuration
- `LED_SEQUENCER_DIM_EN` defined:
  - Adds a free-running 4-bit PWM counter (reset 0, increments every cycle, wraps 15->0).
  - `led_o` becomes a register loaded with `pat & {8{pwm_cnt < 4}}`, giving 25% brightness.
  - `led_o` lags `pat` by one cycle; all latencies above grow by 1 for `led_o` only. `mode_o` is unchanged.
- `LED_SEQUENCER_DIM_EN` undefined: no PWM logic; `led_o` is `pat` directly.

## Test plan
(Bench parameters TICK_DIV=4, DEBOUNCE_CYCLES=3; macro undefined unless stated.)
- Reset, then run 12 cycles with the button high -> `mode_o`=0; `led_o` reads 00, then FF from edge 4, 00 from edge 8, FF from edge 12. Assert `rstn_i` mid-run -> `led_o`=00 immediately, without waiting for a clock edge.
- Hold `button_i` low -> `mode_o`=1 and `led_o`=01 on edge 5. Continue for 32 cycles -> `led_o` sequence 01, 02, 04, …, 80, 01 with a step every 4 cycles. Exactly one mode advance occurs.
- Glitch `button_i` low for 2 cycles, then high -> no mode change. Low for 3+ cycles -> mode advances once. Release and press 4 times in total -> `mode_o` cycles 1, 2, 3, 0.
- BOUNCE mode, 16 ticks -> `led_o` sequence 01, 02, 04, 08, 10, 20, 40, 80, 40, 20, 10, 08, 04, 02, 01, 02. FILL mode, 10 ticks -> 00, 01, 03, 07, 0F, 1F, 3F, 7F, FF, 00.
- Align the debounce acceptance with a tick cycle -> mode advances, `led_o` shows the new init value, and the next step follows 4 cycles later.
- With `LED_SEQUENCER_DIM_EN` defined in CHASE mode -> `led_o`=`pat` for 4 of every 16 cycles and 00 otherwise; `mode_o` timing is unchanged.
